seq_magnitude_comparator: RTL and testbench
===========================================

# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator: compares two WIDTH-bit operands DIGIT bits per clock, MSB digit first, with early termination on the first differing digit. It supports unsigned or two's-complement comparison, selected per operation. Operands enter through a valid/ready request handshake and results leave through a valid/ready response handshake. It is the sequential, width-generic successor to the fixed 16-bit combinational comparator, intended for datapaths where a full-width combinational compare does not close timing.

## Interface
- WIDTH, 16: operand width; must be at least 2.
- DIGIT, 4: bits compared per cycle; must divide WIDTH. NDIG = WIDTH/DIGIT.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  request valid.
- start_ready  out  1  block can accept a request.
- A  in  WIDTH  operand A; sampled on accept.
- B  in  WIDTH  operand B; sampled on accept.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- A_gt_B, A_eq_B, A_lt_B  out  1 each  result flags.
- steps  out  clog2(NDIG)+1  number of digits examined to reach the result (1..NDIG).

## Operation
- States:
  - IDLE: start_ready=1.
  - CMP: compare digits.
  - DONE: res_valid=1.
- Accept: start_valid && start_ready in IDLE.
  - Latch A and B. If signed_mode=1, invert the MSB of both latched operands (offset binary), so that an unsigned compare of the latched values gives the signed ordering.
  - Digit index idx <= NDIG-1. Flags and steps <= 0. Next state CMP.
- CMP, each cycle: compare the digit at bits [idx*DIGIT +: DIGIT] of the latched operands. steps <= steps+1.
  - Digits differ: set A_gt_B or A_lt_B from the digit compare; go to DONE.
  - Digits equal and idx=0: set A_eq_B; go to DONE.
  - Otherwise: idx <= idx-1; stay in CMP.
- DONE: hold flags and steps stable until res_valid && res_ready, then go to IDLE.
- Flag rules:
  - While res_valid=1, exactly one flag is high.
  - Flags and steps keep the last result until the next accept clears them.
- start_ready is high only in IDLE. There is no accept in CMP or DONE; start_valid is ignored in those states.
- Changes to A, B or signed_mode after accept do not affect the operation in flight.

## Timing
- Reset (asynchronous, immediate): state=IDLE, start_ready=1, res_valid=0, all flags 0, steps=0, idx=0, operand registers 0.
- Accept at edge E0: digit NDIG-1 is compared in the cycle after E0. res_valid rises after edge E0+n, where n = steps (1..NDIG).
  - Worst case (equal operands, or difference only in digit 0): NDIG cycles.
  - DIGIT=WIDTH: fixed 1-cycle latency.
- Response handshake at edge Ed: res_valid falls and start_ready rises after Ed. The next accept is possible at edge Ed+1 at the earliest.
  - Peak throughput: one result per n+2 cycles.
- res_ready held low: the block stays in DONE indefinitely with all outputs stable.
- res_ready held high before res_valid rises: the result is still presented for at least one cycle and is consumed at the first edge where res_valid=1.
- Reset asserted mid-CMP or in DONE: operation aborted with no result; outputs take reset values. The first accept is possible on the first edge after rst_n is released.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Unsigned, A=25 (0x0019), B=20 (0x0014) -> A_gt_B=1, steps=4, res_valid 4 cycles after accept.
- A=0x8000, B=0x7FFF: signed_mode=0 -> A_gt_B=1, steps=1; signed_mode=1 -> A_lt_B=1, steps=1.
- A=B=50 -> A_eq_B=1, steps=4. A=15, B=30 -> A_lt_B=1, steps=3. Signed A=0xFFFF, B=0xFFFE -> A_gt_B=1, steps=4.
- Backpressure: result A=1, B=2 with res_ready low for 10 cycles, start_valid held high with A and B toggling each cycle -> flags and steps stable, start_ready=0 throughout. Release res_ready -> start_ready=1 on the next cycle, then a new accept.
- Reset mid-operation: A=0x1234, B=0x1235, rst_n pulsed low 2 cycles after accept -> all outputs 0 immediately and start_ready=1. A following request A=7, B=7 -> A_eq_B=1, steps=4.
- Changing A and B during CMP (accepted A=0x00F0, B=0x00E0) -> result still A_gt_B=1, steps=3.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits per clock,
// MSB digit first, stopping at the first differing digit.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [WIDTH-1:0]                A,
  input  logic [WIDTH-1:0]                B,
  input  logic                            signed_mode,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            A_gt_B,
  output logic                            A_eq_B,
  output logic                            A_lt_B,
  output logic [$clog2(WIDTH/DIGIT):0]    steps
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW   = $clog2(NDIG) + 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] da, db;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    da          = a_q[idx*DIGIT +: DIGIT];
    db          = b_q[idx*DIGIT +: DIGIT];
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = CMP;
      end
      CMP: begin
        if (da != db || idx == '0) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = start_valid && (state == IDLE);

  // Flipping the sign bit maps two's-complement onto offset binary,
  // so the digit walk below is always an unsigned compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      steps  <= '0;
      A_gt_B <= 1'b0;
      A_eq_B <= 1'b0;
      A_lt_B <= 1'b0;
    end else if (accept) begin
      a_q    <= {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
      b_q    <= {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
      idx    <= IW'(NDIG - 1);
      steps  <= '0;
      A_gt_B <= 1'b0;
      A_eq_B <= 1'b0;
      A_lt_B <= 1'b0;
    end else if (state == CMP) begin
      steps <= steps + SW'(1);
      if (da != db) begin
        A_gt_B <= (da > db);
        A_lt_B <= (da < db);
      end else if (idx == '0) begin
        A_eq_B <= 1'b1;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4).
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        signed_mode = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        A_gt_B, A_eq_B, A_lt_B;
  logic [2:0]  steps;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .A(A), .B(B), .signed_mode(signed_mode),
    .res_valid(res_valid), .res_ready(res_ready),
    .A_gt_B(A_gt_B), .A_eq_B(A_eq_B), .A_lt_B(A_lt_B),
    .steps(steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gt;
    logic       eq;
    logic       lt;
    logic [2:0] st;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  logic consumed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on each rising res_valid, then checks the
  // result stays put until the handshake and that the block returns to idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      consumed   = 1'b0;
    end else begin
      if (consumed) begin
        chk("handoff_valid", {31'd0, res_valid}, 0);
        chk("handoff_ready", {31'd0, start_ready}, 1);
        consumed = 1'b0;
      end
      if (res_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("latency", cyc - cur.acc - 1, {29'd0, cur.st});
          chk("flags", {29'd0, A_gt_B, A_eq_B, A_lt_B}, {29'd0, cur.gt, cur.eq, cur.lt});
          chk("steps", {29'd0, steps}, {29'd0, cur.st});
          chk("start_ready_done", {31'd0, start_ready}, 0);
        end
      end else if (res_valid) begin
        chk("hold_flags", {29'd0, A_gt_B, A_eq_B, A_lt_B}, {29'd0, cur.gt, cur.eq, cur.lt});
        chk("hold_steps", {29'd0, steps}, {29'd0, cur.st});
      end
      if (res_valid && res_ready) consumed = 1'b1;
      prev_valid = res_valid;
    end
  end

  task automatic req(input logic [15:0] a, input logic [15:0] b, input logic sm,
                     input logic gt, input logic eq, input logic lt, input logic [2:0] st);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) chk("req_timeout", 0, 1);
    A = a;
    B = b;
    signed_mode = sm;
    start_valid = 1'b1;
    e.gt = gt; e.eq = eq; e.lt = lt; e.st = st; e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && start_ready && !res_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, {31'd0, start_ready}, 1);
    chk({name, "_valid"}, {31'd0, res_valid}, 0);
    chk({name, "_flags"}, {29'd0, A_gt_B, A_eq_B, A_lt_B}, 0);
    chk({name, "_steps"}, {29'd0, steps}, 0);
  endtask

  initial begin
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    //  A         B         sm    gt    eq    lt    steps
    req(16'h0019, 16'h0014, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4); wait_done();
    req(16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1); wait_done();
    req(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1); wait_done();
    req(16'd50,   16'd50,   1'b0, 1'b0, 1'b1, 1'b0, 3'd4); wait_done();
    req(16'd15,   16'd30,   1'b0, 1'b0, 1'b0, 1'b1, 3'd3); wait_done();
    req(16'hFFFF, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4); wait_done();
    req(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1); wait_done();
    req(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4); wait_done();

    // Operands change while the compare is in flight.
    req(16'h00F0, 16'h00E0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    @(negedge clk);
    A = 16'h0000; B = 16'hFFFF; signed_mode = 1'b1;
    wait_done();

    // Backpressure with a persistent, changing request.
    res_ready = 1'b0;
    req(16'd1, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    start_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      A = ~A;
      B = B ^ 16'h5A5A;
      chk("bp_start_ready", {31'd0, start_ready}, 0);
    end
    chk("bp_valid_held", {31'd0, res_valid}, 1);
    start_valid = 1'b0;
    res_ready = 1'b1;
    wait_done();
    req(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2); wait_done();

    // Reset two cycles into a compare.
    req(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    sb.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    req(16'd7, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4); wait_done();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
